uart_mon_ctrl: RTL and testbench
================================

// Module: uart_mon_ctrl
// PURPOSE
//  Command sequencer for the RISC-V monitor. Sits between the UART byte receiver
//  and transmitter. Parses host command frames from the rx byte stream and issues
//  32-bit memory bus reads and writes or CPU reset-hold control. Returns response
//  bytes by sequencing the single UART transmitter one byte at a time.
// PARAMETERS
//  ADDR_W       32   memory address width; wider received address bits are dropped
//  ACK_TIMEOUT  255  max cycles mem_req may wait for mem_ack before abort (>=1)
// PORTS
//  clk              in   1       system clock (27 MHz)
//  rst_n            in   1       asynchronous reset, active low
//  rx_data_valid    in   1       1-cycle pulse: rx_data holds a received byte
//  rx_data          in   8       received byte
//  rx_block_timeout in   1       1-cycle pulse: rx line idle gap, ends a host block
//  tx_bsy           in   1       transmitter busy with a frame
//  tx_send_trig     out  1       1-cycle pulse that starts a tx frame
//  tx_send_data     out  8       byte to transmit; held stable while the byte is in flight
//  mem_req          out  1       bus request, held until ack or timeout
//  mem_we           out  1       1 = write, 0 = read; valid while mem_req
//  mem_addr         out  ADDR_W  word address; valid while mem_req
//  mem_wdata        out  32      write data; valid while mem_req
//  mem_ack          in   1       bus completion, sampled only while mem_req=1
//  mem_rdata        in   32      read data, valid in the mem_ack cycle
//  cpu_rst_hold     out  1       1 = hold CPU in reset
//  busy             out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except cpu_rst_hold=1. State goes to IDLE. Counters are cleared.
//  Reset mid-operation aborts immediately; mem_req and tx_send_trig drop asynchronously.
//  Frames: multi-byte fields are sent LSB first.
//   'R'(0x52) A0..A3        -> read;  response D0..D3 (mem_rdata, LSB first)
//   'W'(0x57) A0..A3 D0..D3 -> write; response 0x06
//   'C'(0x43) B             -> cpu_rst_hold<=B[0]; response 0x06
//   other opcode            -> response 0x15 (NAK); no further bytes consumed
//  States: IDLE, GET_ADDR, GET_DATA, GET_CTRL, BUS, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO.
//   IDLE: on rx byte, decode opcode -> GET_ADDR / GET_CTRL / (NAK) TX_LOAD.
//   GET_ADDR: collect 4 bytes via 2-bit byte counter. After the 4th: 'R' -> BUS, 'W' -> GET_DATA.
//   GET_DATA: collect 4 bytes, then -> BUS.
//   GET_CTRL: 1 byte, update cpu_rst_hold, then -> TX_LOAD (ACK).
//   BUS: mem_req=1 the cycle after the last byte is received. addr, we, wdata stay stable.
//    On mem_ack: capture mem_rdata. mem_req=0 the next cycle. Then -> TX_LOAD.
//    If ACK_TIMEOUT cycles elapse with no ack: mem_req=0, response NAK, -> TX_LOAD.
//   TX_LOAD: drive tx_send_data. When tx_bsy=0, pulse tx_send_trig for 1 cycle.
//    Then -> TX_WAIT_HI.
//   TX_WAIT_HI: wait for tx_bsy=1, then -> TX_WAIT_LO.
//   TX_WAIT_LO: wait for tx_bsy=0. If bytes remain, go to TX_LOAD with the next byte;
//    otherwise -> IDLE.
//   Response buffer: 32 bits plus a length of 1 or 4; shifted right by 8 per byte sent.
//  rx_block_timeout in GET_* states aborts the command: -> IDLE, no response.
//   It is ignored in all other states.
//  Same cycle rx_data_valid and rx_block_timeout: timeout wins; the byte is discarded.
//  rx bytes arriving in BUS or TX_* states are dropped. The host waits for the response.
//  mem_addr = received 32-bit address truncated to ADDR_W (zero-extended if ADDR_W>32).
//  The ACK_TIMEOUT counter is 8+ bits wide, clears on BUS entry, and saturates.
// TESTING
//  Write: rx 57 00 01 00 00 EF BE AD DE -> mem_req/we=1, addr=0x100,
//   wdata=0xDEADBEEF; ack -> tx 0x06.
//  Read: rx 52 04 00 00 00, ack with rdata=0x12345678 -> tx 78 56 34 12,
//   one trig per tx_bsy fall.
//  Control: rx 43 00 -> cpu_rst_hold 1->0, tx 0x06; rx 43 01 -> back to 1.
//  Bad opcode 0xAA -> tx 0x15, busy returns to 0, next valid frame works.
//  Bus timeout: rx read, never ack -> mem_req drops after 255 cycles, tx 0x15.
//  Abort: rx 57 00 01 then block_timeout -> IDLE, no tx, no mem_req.
//   Reset asserted during BUS -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_mon_ctrl.sv
// UART monitor command sequencer: parses host frames from the rx byte stream,
// runs 32-bit bus reads/writes or CPU reset-hold control, and streams responses.
module uart_mon_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_data_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_block_timeout,
  input  logic              tx_bsy,
  output logic              tx_send_trig,
  output logic [7:0]        tx_send_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_rst_hold,
  output logic              busy
);

  localparam int TCLOG = $clog2(ACK_TIMEOUT + 1);
  localparam int TW    = (TCLOG > 8) ? TCLOG : 8;

  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = '1;

  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_C = 8'h43;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    GET_CTRL,
    BUS,
    TX_LOAD,
    TX_WAIT_HI,
    TX_WAIT_LO
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   resp_q, resp_d;
  logic [2:0]    len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          hold_q, hold_d;

  logic byte_v;
  logic abort;

  // A block timeout in the same cycle as a byte discards that byte.
  assign byte_v = rx_data_valid & ~rx_block_timeout;
  assign abort  = rx_block_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (byte_v) begin
          unique case (1'b1)
            (rx_data == OP_R): begin
              we_d    = 1'b0;
              state_d = GET_ADDR;
            end
            (rx_data == OP_W): begin
              we_d    = 1'b1;
              state_d = GET_ADDR;
            end
            (rx_data == OP_C): begin
              state_d = GET_CTRL;
            end
            default: begin
              resp_d  = {24'h0, NAK};
              len_d   = 3'd1;
              state_d = TX_LOAD;
            end
          endcase
        end
      end

      GET_ADDR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (byte_v) begin
          addr_d = {rx_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            tmo_d   = '0;
            state_d = we_q ? GET_DATA : BUS;
          end
        end
      end

      GET_DATA: begin
        if (abort) begin
          state_d = IDLE;
        end else if (byte_v) begin
          wdata_d = {rx_data, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            tmo_d   = '0;
            state_d = BUS;
          end
        end
      end

      GET_CTRL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (byte_v) begin
          hold_d  = rx_data[0];
          resp_d  = {24'h0, ACK};
          len_d   = 3'd1;
          state_d = TX_LOAD;
        end
      end

      BUS: begin
        if (mem_ack) begin
          resp_d  = we_q ? {24'h0, ACK} : mem_rdata;
          len_d   = we_q ? 3'd1 : 3'd4;
          state_d = TX_LOAD;
        end else if (tmo_q == TMO_LAST) begin
          resp_d  = {24'h0, NAK};
          len_d   = 3'd1;
          state_d = TX_LOAD;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      TX_LOAD: begin
        if (!tx_bsy) begin
          state_d = TX_WAIT_HI;
        end
      end

      TX_WAIT_HI: begin
        if (tx_bsy) begin
          state_d = TX_WAIT_LO;
        end
      end

      TX_WAIT_LO: begin
        if (!tx_bsy) begin
          resp_d = {8'h0, resp_q[31:8]};
          if (len_q > 3'd1) begin
            len_d   = len_q - 3'd1;
            state_d = TX_LOAD;
          end else begin
            len_d   = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req      = (state_q == BUS);
  assign mem_we       = mem_req & we_q;
  assign mem_wdata    = wdata_q;
  assign tx_send_trig = (state_q == TX_LOAD) & ~tx_bsy;
  assign tx_send_data = resp_q[7:0];
  assign cpu_rst_hold = hold_q;
  assign busy         = (state_q != IDLE);

  generate
    if (ADDR_W <= 32) begin : g_addr_trunc
      assign mem_addr = addr_q[ADDR_W-1:0];
    end else begin : g_addr_ext
      assign mem_addr = {{(ADDR_W-32){1'b0}}, addr_q};
    end
  endgenerate

endmodule

// File: tb/tb_uart_mon_ctrl.sv
// Bench for uart_mon_ctrl: vector table, corner sequences and random
// frames checked against a frame-level model with modelled UART and bus.
module tb_uart_mon_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_data_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_block_timeout = 1'b0;
  logic        tx_bsy = 1'b0;
  logic        tx_send_trig;
  logic [7:0]  tx_send_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_rst_hold;
  logic        busy;

  uart_mon_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_data_valid    (rx_data_valid),
    .rx_data          (rx_data),
    .rx_block_timeout (rx_block_timeout),
    .tx_bsy           (tx_bsy),
    .tx_send_trig     (tx_send_trig),
    .tx_send_data     (tx_send_data),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .cpu_rst_hold     (cpu_rst_hold),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C5A_A5C3;
  endfunction

  // UART transmitter model: accepts a trig, stays busy a random time.
  logic [7:0] txq[$];
  logic [7:0] cur;
  int bcnt = 0;
  bit starting = 0;
  int stab = 0;
  int dbl = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      tx_bsy = 1'b0;
      bcnt = 0;
      starting = 0;
    end else if (starting) begin
      starting = 0;
      if (tx_send_trig) dbl++;
      tx_bsy = 1'b1;
      bcnt = int'($urandom_range(1, 5));
    end else if (tx_bsy) begin
      if (tx_send_data !== cur) stab++;
      if (bcnt == 0) tx_bsy = 1'b0;
      else bcnt--;
    end else if (tx_send_trig) begin
      cur = tx_send_data;
      txq.push_back(cur);
      starting = 1;
    end
  end

  // Bus slave model: acks after ack_dly request cycles, never if negative.
  int ack_dly = 0;
  bit ovr_en = 0;
  logic [31:0] ovr_rd = 32'h0;
  logic [31:0] smem[logic [31:0]];
  int req_cyc = 0;
  int n_req = 0;
  int last_len = 0;
  int unstable = 0;
  logic seen_we;
  logic [31:0] seen_addr;
  logic [31:0] seen_wd;

  always @(negedge clk) begin
    if (mem_req) begin
      if (req_cyc == 0) begin
        n_req++;
        seen_we = mem_we;
        seen_addr = mem_addr;
        seen_wd = mem_wdata;
      end else if (mem_we !== seen_we || mem_addr !== seen_addr ||
                   mem_wdata !== seen_wd) begin
        unstable++;
      end
      if (ack_dly >= 0 && req_cyc == ack_dly) begin
        mem_ack = 1'b1;
        if (mem_we) smem[mem_addr] = mem_wdata;
        if (ovr_en) mem_rdata = ovr_rd;
        else if (smem.exists(mem_addr)) mem_rdata = smem[mem_addr];
        else mem_rdata = dflt(mem_addr);
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
      req_cyc++;
    end else begin
      if (req_cyc != 0) last_len = req_cyc;
      req_cyc = 0;
      mem_ack = 1'b0;
    end
  end

  logic [7:0] frame_q[$];

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_data_valid = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frame_q[j]) send_byte(frame_q[j]);
  endtask

  task automatic pulse_tmo();
    @(negedge clk);
    rx_block_timeout = 1'b1;
    @(negedge clk);
    rx_block_timeout = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((busy || tx_bsy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle"}, 32'(busy), 32'h0);
  endtask

  task automatic chk_tx(input string nm, input logic [7:0] exq[$]);
    logic [31:0] act;
    chk({nm, "_txn"}, 32'(txq.size()), 32'(exq.size()));
    foreach (exq[j]) begin
      act = (j < txq.size()) ? {24'h0, txq[j]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_tx%0d", nm, j), act, {24'h0, exq[j]});
    end
  endtask

  typedef struct {
    int          n;
    logic [71:0] rx;
    int          dly;
    logic [31:0] rdata;
    int          en;
    logic [31:0] etx;
    bit          ereq;
    bit          ewe;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    bit          ehold;
  } vec_t;

  vec_t vt[10];
  logic [7:0] exq[$];
  logic [31:0] mem_m[logic [31:0]];
  logic [31:0] pool[8];
  bit hold_m;

  initial begin
    vt[0] = '{9, 72'hDEADBEEF_00000100_57, 3, 0, 1, 32'h06,
              1, 1, 32'h100, 32'hDEADBEEF, 1};
    vt[1] = '{5, 72'h00000004_52, 0, 32'h12345678, 4, 32'h12345678,
              1, 0, 32'h4, 0, 1};
    vt[2] = '{2, 72'h00_43, 0, 0, 1, 32'h06, 0, 0, 0, 0, 0};
    vt[3] = '{2, 72'h01_43, 0, 0, 1, 32'h06, 0, 0, 0, 0, 1};
    vt[4] = '{1, 72'hAA, 0, 0, 1, 32'h15, 0, 0, 0, 0, 1};
    vt[5] = '{5, 72'h00000010_52, -1, 0, 1, 32'h15,
              1, 0, 32'h10, 0, 1};
    vt[6] = '{2, 72'hFE_43, 0, 0, 1, 32'h06, 0, 0, 0, 0, 0};
    vt[7] = '{9, 72'h04030201_7FFFFFF0_57, 7, 0, 1, 32'h06,
              1, 1, 32'h7FFFFFF0, 32'h04030201, 0};
    vt[8] = '{5, 72'h7FFFFFF0_52, 1, 32'hA5C30F1E, 4, 32'hA5C30F1E,
              1, 0, 32'h7FFFFFF0, 0, 0};
    vt[9] = '{2, 72'h03_43, 0, 0, 1, 32'h06, 0, 0, 0, 0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_trig", 32'(tx_send_trig), 0);
    chk("rst_txd", 32'(tx_send_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hold", 32'(cpu_rst_hold), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      frame_q.delete();
      for (int j = 0; j < vt[i].n; j++) frame_q.push_back(vt[i].rx[8*j +: 8]);
      exq.delete();
      for (int j = 0; j < vt[i].en; j++) exq.push_back(vt[i].etx[8*j +: 8]);
      ack_dly = vt[i].dly;
      ovr_en = 1;
      ovr_rd = vt[i].rdata;
      txq.delete();
      n_req = 0;
      last_len = 0;
      send_frame();
      wait_idle($sformatf("v%0d", i));
      repeat (2) @(negedge clk);
      chk_tx($sformatf("v%0d", i), exq);
      chk($sformatf("v%0d_nreq", i), 32'(n_req), vt[i].ereq ? 32'd1 : 32'd0);
      if (vt[i].ereq) begin
        chk($sformatf("v%0d_we", i), 32'(seen_we), 32'(vt[i].ewe));
        chk($sformatf("v%0d_addr", i), seen_addr, vt[i].eaddr);
        if (vt[i].ewe) chk($sformatf("v%0d_wd", i), seen_wd, vt[i].ewd);
        chk($sformatf("v%0d_reqlen", i), 32'(last_len),
            vt[i].dly < 0 ? 32'd255 : 32'(vt[i].dly + 1));
      end
      chk($sformatf("v%0d_hold", i), 32'(cpu_rst_hold), 32'(vt[i].ehold));
    end

    // Abort mid-address: no response, no bus request
    txq.delete();
    n_req = 0;
    frame_q = '{8'h57, 8'h00, 8'h01};
    send_frame();
    pulse_tmo();
    repeat (10) @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_tx", 32'(txq.size()), 0);
    chk("abort_req", 32'(n_req), 0);

    // Byte and timeout together: timeout wins in GET_ADDR and in IDLE
    send_byte(8'h52);
    @(negedge clk);
    rx_data = 8'h04;
    rx_data_valid = 1'b1;
    rx_block_timeout = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
    rx_block_timeout = 1'b0;
    chk("both_get_busy", 32'(busy), 0);
    @(negedge clk);
    rx_data = 8'h43;
    rx_data_valid = 1'b1;
    rx_block_timeout = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
    rx_block_timeout = 1'b0;
    chk("both_idle_busy", 32'(busy), 0);
    chk("both_tx", 32'(txq.size()), 0);
    frame_q = '{8'h43, 8'h00};
    send_frame();
    wait_idle("both_c0");
    exq = '{8'h06};
    chk_tx("both_c0", exq);
    chk("both_c0_hold", 32'(cpu_rst_hold), 0);
    txq.delete();
    frame_q = '{8'h43, 8'h01};
    send_frame();
    wait_idle("both_c1");
    chk("both_c1_hold", 32'(cpu_rst_hold), 1);

    // Bytes arriving during BUS are dropped
    txq.delete();
    n_req = 0;
    ack_dly = 15;
    ovr_rd = 32'hCAFEF00D;
    frame_q = '{8'h52, 8'h20, 8'h00, 8'h00, 8'h00};
    send_frame();
    chk("drop_req_next", 32'(mem_req), 1);
    send_byte(8'h43);
    send_byte(8'h00);
    send_byte(8'hAA);
    wait_idle("drop");
    repeat (2) @(negedge clk);
    exq = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    chk_tx("drop", exq);
    chk("drop_hold", 32'(cpu_rst_hold), 1);
    chk("drop_nreq", 32'(n_req), 1);
    chk("drop_addr", seen_addr, 32'h20);

    // Reset while in BUS
    frame_q = '{8'h43, 8'h00};
    send_frame();
    wait_idle("prerst");
    chk("prerst_hold", 32'(cpu_rst_hold), 0);
    ack_dly = -1;
    frame_q = '{8'h52, 8'h30, 8'h00, 8'h00, 8'h00};
    send_frame();
    repeat (5) @(negedge clk);
    chk("prerst_req", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_we", 32'(mem_we), 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_trig", 32'(tx_send_trig), 0);
    chk("arst_txd", 32'(tx_send_data), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_hold", 32'(cpu_rst_hold), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Random frames against a frame-level model
    hold_m = 1;
    ovr_en = 0;
    smem.delete();
    foreach (pool[j]) pool[j] = $urandom;
    for (int it = 0; it < 60; it++) begin
      int kind;
      int dly;
      int k;
      bit abrt;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] v;
      logic [7:0] op;
      logic [7:0] cb;
      kind = int'($urandom_range(0, 9));
      a = pool[$urandom_range(0, 7)];
      d = $urandom;
      cb = 8'($urandom);
      dly = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 6));
      frame_q.delete();
      exq.delete();
      if (kind <= 3) begin
        frame_q.push_back(8'h52);
        for (int j = 0; j < 4; j++) frame_q.push_back(a[8*j +: 8]);
      end else if (kind <= 6) begin
        frame_q.push_back(8'h57);
        for (int j = 0; j < 4; j++) frame_q.push_back(a[8*j +: 8]);
        for (int j = 0; j < 4; j++) frame_q.push_back(d[8*j +: 8]);
      end else if (kind <= 8) begin
        frame_q.push_back(8'h43);
        frame_q.push_back(cb);
      end else begin
        do op = 8'($urandom);
        while (op == 8'h52 || op == 8'h57 || op == 8'h43);
        frame_q.push_back(op);
      end
      abrt = (kind <= 8) && ($urandom_range(0, 7) == 0);
      txq.delete();
      ack_dly = dly;
      if (abrt) begin
        k = int'($urandom_range(1, frame_q.size() - 1));
        for (int j = 0; j < k; j++) send_byte(frame_q[j]);
        pulse_tmo();
        repeat (3) @(negedge clk);
        chk($sformatf("r%0d_abort_busy", it), 32'(busy), 0);
        chk($sformatf("r%0d_abort_tx", it), 32'(txq.size()), 0);
      end else begin
        send_frame();
        if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
        wait_idle($sformatf("r%0d", it));
        repeat (2) @(negedge clk);
        if (kind <= 3) begin
          if (dly < 0) begin
            exq.push_back(8'h15);
          end else begin
            v = mem_m.exists(a) ? mem_m[a] : dflt(a);
            for (int j = 0; j < 4; j++) exq.push_back(v[8*j +: 8]);
          end
        end else if (kind <= 6) begin
          if (dly < 0) begin
            exq.push_back(8'h15);
          end else begin
            mem_m[a] = d;
            exq.push_back(8'h06);
          end
        end else if (kind <= 8) begin
          hold_m = cb[0];
          exq.push_back(8'h06);
        end else begin
          exq.push_back(8'h15);
        end
        chk_tx($sformatf("r%0d", it), exq);
        chk($sformatf("r%0d_hold", it), 32'(cpu_rst_hold), 32'(hold_m));
      end
    end

    chk("tx_data_stable", 32'(stab), 0);
    chk("trig_single", 32'(dbl), 0);
    chk("bus_stable", 32'(unstable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
